// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - request, result and full-subtractor signals of serial_sub_ctrl
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             borrow_in;
    logic             in_ready;
    logic             busy;
    logic             fs_a;
    logic             fs_b;
    logic             fs_c;
    logic             fs_diff;
    logic             fs_borrow;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             borrow_out;

    modport slave (
        input  start, in_a, in_b, borrow_in, fs_diff, fs_borrow, res_ready,
        output in_ready, busy, fs_a, fs_b, fs_c, res_valid, result, borrow_out
    );

    modport master (
        output start, in_a, in_b, borrow_in, fs_diff, fs_borrow, res_ready,
        input  in_ready, busy, fs_a, fs_b, fs_c, res_valid, result, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - LSB-first bit-serial A - B - borrow_in using an external 1-bit full subtractor
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_sh;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             run;
    logic             in_ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic             borrow_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            result_sh    <= '0;
            cnt          <= '0;
            brw          <= 1'b0;
            run          <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh       <= bus.in_a;
                        b_sh       <= bus.in_b;
                        brw        <= bus.borrow_in;
                        cnt        <= '0;
                        run        <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_sh <= {bus.fs_diff, result_sh[WIDTH-1:1]};
                    brw       <= bus.fs_borrow;
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    if (cnt == LAST) begin
                        // counter is cleared rather than incremented so it never wraps
                        cnt          <= '0;
                        run          <= 1'b0;
                        res_valid_q  <= 1'b1;
                        borrow_out_q <= bus.fs_borrow;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // subtractor inputs come only from flops, gated to zero outside RUN
    assign bus.fs_a       = run & a_sh[0];
    assign bus.fs_b       = run & b_sh[0];
    assign bus.fs_c       = run & brw;
    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.result     = result_sh;
    assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - randomized self-checking bench for serial_sub_ctrl at WIDTH 8 and 4
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(4)) if4 ();

    serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_sub_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // external 1-bit full subtractors
    assign if8.fs_diff   = if8.fs_a ^ if8.fs_b ^ if8.fs_c;
    assign if8.fs_borrow = (~if8.fs_a & if8.fs_b) | (~if8.fs_a & if8.fs_c) | (if8.fs_b & if8.fs_c);
    assign if4.fs_diff   = if4.fs_a ^ if4.fs_b ^ if4.fs_c;
    assign if4.fs_borrow = (~if4.fs_a & if4.fs_b) | (~if4.fs_a & if4.fs_c) | (if4.fs_b & if4.fs_c);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_diff(input int a, input int b, input int bi, input int w);
        int d;
        d = a - b - bi;
        if (d < 0) d = d + (1 << w);
        return d;
    endfunction

    function automatic logic model_borrow(input int a, input int b, input int bi);
        return (a < b + bi);
    endfunction

    // borrow entering bit i is set iff the low i bits of A are below those of B plus borrow_in
    function automatic logic [7:0] model_ripple(input int a, input int b, input int bi);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ((a % (1 << i)) < ((b % (1 << i)) + bi));
        end
        return r;
    endfunction

    task automatic do_op8(input int a, input int b, input int bi, input string name);
        int         lat;
        logic [7:0] fsc;
        logic [7:0] exp_fsc;
        exp_fsc = model_ripple(a, b, bi);
        fsc = '0;
        if8.res_ready = 1'b1;
        n_checks++;
        if (if8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_in_ready got %b exp 1", name, if8.in_ready);
        end
        if8.in_a = 8'(a);
        if8.in_b = 8'(b);
        if8.borrow_in = 1'(bi);
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        if8.in_a = 8'($urandom);
        if8.in_b = 8'($urandom);
        if8.borrow_in = 1'($urandom);
        lat = 0;
        while (if8.res_valid !== 1'b1 && lat < 20) begin
            if (lat < 8) fsc[lat] = if8.fs_c;
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL %s latency got %0d exp 8", name, lat);
        end
        n_checks++;
        if (if8.result !== 8'(model_diff(a, b, bi, 8)) || if8.borrow_out !== model_borrow(a, b, bi)) begin
            n_fail++;
            $display("FAIL %s result got %h/%b exp %h/%b", name, if8.result, if8.borrow_out,
                     8'(model_diff(a, b, bi, 8)), model_borrow(a, b, bi));
        end
        n_checks++;
        if (fsc !== exp_fsc) begin
            n_fail++;
            $display("FAIL %s fs_c_ripple got %b exp %b", name, fsc, exp_fsc);
        end
        step();
        n_checks++;
        if (if8.res_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_handshake res_valid %b in_ready %b exp 0 1", name, if8.res_valid, if8.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({if8.in_ready, if8.busy, if8.res_valid, if8.result, if8.borrow_out, if8.fs_a, if8.fs_b, if8.fs_c}
            !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset8 got rdy %b busy %b vld %b res %h bo %b fs %b%b%b exp 1 0 0 00 0 000",
                     if8.in_ready, if8.busy, if8.res_valid, if8.result, if8.borrow_out, if8.fs_a, if8.fs_b, if8.fs_c);
        end
        n_checks++;
        if ({if4.in_ready, if4.busy, if4.res_valid, if4.result, if4.borrow_out} !== {3'b100, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset4 got rdy %b busy %b vld %b res %h bo %b exp 1 0 0 0 0",
                     if4.in_ready, if4.busy, if4.res_valid, if4.result, if4.borrow_out);
        end
    endtask

    task automatic test_basic();
        do_op8(8'h5A, 8'h3C, 0, "basic");
    endtask

    task automatic test_borrow();
        do_op8(8'h00, 8'h01, 0, "borrow_0_1");
        do_op8(8'h10, 8'h10, 1, "borrow_10_10_1");
        do_op8(8'h80, 8'h7F, 1, "borrow_80_7f_1");
        for (int i = 0; i < 4; i++) begin
            do_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "random8");
        end
    endtask

    task automatic test_backpressure();
        int a, b, bi, lat;
        logic [7:0] er;
        logic       eb;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        bi = int'($urandom_range(0, 1));
        er = 8'(model_diff(a, b, bi, 8));
        eb = model_borrow(a, b, bi);
        if8.res_ready = 1'b0;
        if8.in_a = 8'(a);
        if8.in_b = 8'(b);
        if8.borrow_in = 1'(bi);
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        lat = 0;
        while (if8.res_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL bp_latency got %0d exp 8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            if8.start = 1'b1;
            if8.in_a = 8'($urandom);
            if8.in_b = 8'($urandom);
            if8.borrow_in = 1'($urandom);
            step();
            n_checks++;
            if (if8.res_valid !== 1'b1 || if8.result !== er || if8.borrow_out !== eb
                || if8.in_ready !== 1'b0 || if8.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got vld %b res %h bo %b rdy %b busy %b exp 1 %h %b 0 1",
                         i, if8.res_valid, if8.result, if8.borrow_out, if8.in_ready, if8.busy, er, eb);
            end
        end
        // start coinciding with the result handshake edge must be dropped
        if8.res_ready = 1'b1;
        step();
        n_checks++;
        if (if8.res_valid !== 1'b0 || if8.in_ready !== 1'b1 || if8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got vld %b rdy %b busy %b exp 0 1 0", if8.res_valid, if8.in_ready, if8.busy);
        end
        if8.start = 1'b0;
        do_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1, "bp_next");
    endtask

    task automatic test_reset_mid();
        if8.res_ready = 1'b1;
        if8.in_a = 8'hFF;
        if8.in_b = 8'hFF;
        if8.borrow_in = 1'b1;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (if8.busy !== 1'b1 || if8.fs_c !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_state got busy %b fs_c %b exp 1 1", if8.busy, if8.fs_c);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({if8.in_ready, if8.busy, if8.res_valid, if8.result, if8.borrow_out, if8.fs_a, if8.fs_b, if8.fs_c}
            !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset got rdy %b busy %b vld %b res %h bo %b fs %b%b%b exp 1 0 0 00 0 000",
                     if8.in_ready, if8.busy, if8.res_valid, if8.result, if8.borrow_out, if8.fs_a, if8.fs_b, if8.fs_c);
        end
        do_op8(8'hF0, 8'h0F, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int   opa[3] = '{8'h01, 8'hFF, 8'h00};
        int   opb[3] = '{8'h01, 8'h00, 8'hFF};
        int   acc_edge[3];
        int   e, nacc, nres;
        logic acc_now;
        e = 0;
        nacc = 0;
        nres = 0;
        if8.res_ready = 1'b1;
        if8.borrow_in = 1'b0;
        if8.in_a = 8'(opa[0]);
        if8.in_b = 8'(opb[0]);
        if8.start = 1'b1;
        while (nres < 3 && e < 60) begin
            acc_now = if8.in_ready && if8.start;
            step();
            e++;
            if (acc_now) begin
                acc_edge[nacc] = e;
                nacc++;
                if (nacc < 3) begin
                    if8.in_a = 8'(opa[nacc]);
                    if8.in_b = 8'(opb[nacc]);
                end else begin
                    if8.start = 1'b0;
                end
            end
            if (if8.res_valid === 1'b1) begin
                n_checks++;
                if (if8.result !== 8'(model_diff(opa[nres], opb[nres], 0, 8))
                    || if8.borrow_out !== model_borrow(opa[nres], opb[nres], 0)) begin
                    n_fail++;
                    $display("FAIL b2b_result op %0d got %h/%b exp %h/%b", nres, if8.result, if8.borrow_out,
                             8'(model_diff(opa[nres], opb[nres], 0, 8)), model_borrow(opa[nres], opb[nres], 0));
                end
                nres++;
            end
        end
        if8.start = 1'b0;
        n_checks++;
        if (nres !== 3 || nacc !== 3) begin
            n_fail++;
            $display("FAIL b2b_count got results %0d accepts %0d exp 3 3", nres, nacc);
        end else begin
            n_checks++;
            if (acc_edge[1] - acc_edge[0] !== 10 || acc_edge[2] - acc_edge[1] !== 10) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d %0d exp 10 10", acc_edge[1] - acc_edge[0], acc_edge[2] - acc_edge[1]);
            end
        end
        step();
        step();
    endtask

    task automatic test_exhaustive4();
        int   budget;
        int   bad;
        logic done;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    budget = 0;
                    while (if4.in_ready !== 1'b1 && budget < 20) begin
                        step();
                        budget++;
                    end
                    if4.in_a = 4'(a);
                    if4.in_b = 4'(b);
                    if4.borrow_in = 1'(bi);
                    if4.start = 1'b1;
                    step();
                    if4.start = 1'b0;
                    budget = 0;
                    while (if4.res_valid !== 1'b1 && budget < 20) begin
                        if4.res_ready = 1'($urandom);
                        step();
                        budget++;
                    end
                    n_checks++;
                    if (if4.res_valid !== 1'b1 || if4.result !== 4'(model_diff(a, b, bi, 4))
                        || if4.borrow_out !== model_borrow(a, b, bi)) begin
                        n_fail++;
                        bad++;
                        if (bad < 10)
                            $display("FAIL exh4 %h-%h-%0d got vld %b res %h bo %b exp 1 %h %b", a, b, bi,
                                     if4.res_valid, if4.result, if4.borrow_out, 4'(model_diff(a, b, bi, 4)),
                                     model_borrow(a, b, bi));
                    end
                    done = 1'b0;
                    budget = 0;
                    while (!done && budget < 20) begin
                        if4.res_ready = 1'($urandom);
                        done = if4.res_ready;
                        step();
                        budget++;
                    end
                end
            end
        end
        if4.res_ready = 1'b1;
        step();
        n_checks++;
        if (if4.in_ready !== 1'b1 || if4.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exh4_final got rdy %b vld %b exp 1 0", if4.in_ready, if4.res_valid);
        end
    endtask

    initial begin
        if8.start = 1'b0;
        if8.in_a = '0;
        if8.in_b = '0;
        if8.borrow_in = 1'b0;
        if8.res_ready = 1'b1;
        if4.start = 1'b0;
        if4.in_a = '0;
        if4.in_b = '0;
        if4.borrow_in = 1'b0;
        if4.res_ready = 1'b1;
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
